// File: rtl/counter_8bit_timer_ctrl.sv
// Timer sequencer for an up-counter: prescaled stepping, programmable terminal
// count, one-shot/periodic modes, one-cycle terminal pulse and sticky irq.
module counter_8bit_timer_ctrl #(
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  input  logic                   periodic,
  input  logic [WIDTH-1:0]       load_val,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   irq_clr,
  output logic [WIDTH-1:0]       count,
  output logic [1:0]             state,
  output logic                   busy,
  output logic                   tc_pulse,
  output logic                   irq
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]       term;
    logic [PRESC_WIDTH-1:0] presc;
    logic                   mode;   // 1 = periodic
  } cfg_t;

  state_t                 state_q, state_d;
  cfg_t                   cfg_q, cfg_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [PRESC_WIDTH-1:0] pc_q, pc_d;
  logic                   tc_q, tc_d;
  logic                   irq_q, irq_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      tc_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      tc_q    <= tc_d;
      irq_q   <= irq_d;
    end
  end

  // Priority: stop > start > pause > counting.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    tc_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      pc_d    = '0;
    end else if (start) begin
      cfg_d   = '{term: load_val, presc: prescale, mode: periodic};
      cnt_d   = '0;
      pc_d    = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (pc_q == cfg_q.presc) begin
            pc_d = '0;
            if (cnt_q == cfg_q.term) begin
              tc_d = 1'b1;
              if (cfg_q.mode) cnt_d = '0;
              else            state_d = DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        // Resume costs one cycle; prescaler phase is kept across the hold.
        HOLD: if (!pause) state_d = RUN;
        default: ;
      endcase
    end
    irq_d = tc_d | (irq_q & ~irq_clr);
  end

  assign count    = cnt_q;
  assign state    = state_q;
  assign busy     = (state_q == RUN) || (state_q == HOLD);
  assign tc_pulse = tc_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_counter_8bit_timer_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared each cycle against a behavioural model.
module tb_counter_8bit_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 0, stop = 0, pause = 0, periodic = 0, irq_clr = 0;
  logic [7:0] load_val = '0;
  logic [3:0] prescale = '0;
  logic [7:0] count;
  logic [1:0] state;
  logic       busy, tc_pulse, irq;

  int checks = 0;
  int errors = 0;

  counter_8bit_timer_ctrl #(.WIDTH(8), .PRESC_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .load_val(load_val), .prescale(prescale),
    .irq_clr(irq_clr), .count(count), .state(state), .busy(busy),
    .tc_pulse(tc_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode names follow the output encoding: 0 idle, 1 run, 2 hold, 3 done.
  int m_mode, m_count, m_ticks, m_term, m_div, m_auto;
  bit m_tc, m_irq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_count = 0; m_ticks = 0; m_term = 0; m_div = 0; m_auto = 0;
      m_tc = 0; m_irq = 0;
    end else begin
      bit terminal;
      terminal = 0;
      if (stop) begin
        m_mode = 0; m_count = 0; m_ticks = 0;
      end else if (start) begin
        m_term = load_val; m_div = int'(prescale) + 1; m_auto = periodic;
        m_count = 0; m_ticks = 0; m_mode = 1;
      end else if (m_mode == 1 && pause) begin
        m_mode = 2;
      end else if (m_mode == 2 && !pause) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        // one step per m_div running cycles
        m_ticks = m_ticks + 1;
        if (m_ticks == m_div) begin
          m_ticks = 0;
          if (m_count == m_term) begin
            terminal = 1;
            if (m_auto != 0) m_count = 0;
            else m_mode = 3;
          end else begin
            m_count = m_count + 1;
          end
        end
      end
      m_tc  = terminal;
      m_irq = terminal || (m_irq && !irq_clr);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("model_count", count, m_count);
      chk("model_state", state, m_mode);
      chk("model_busy", busy, (m_mode == 1 || m_mode == 2) ? 1 : 0);
      chk("model_tc", tc_pulse, m_tc);
      chk("model_irq", irq, m_irq);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input int lv, input int ps, input bit per);
    start = 1; load_val = 8'(lv); prescale = 4'(ps); periodic = per;
    cyc();
    start = 0;
  endtask

  initial begin
    #3;
    chk("reset_count", count, 0);
    chk("reset_state", state, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tc", tc_pulse, 0);
    chk("reset_irq", irq, 0);
    cyc();
    reset_n = 1;
    cyc();

    // one-shot, term 3, no prescale
    do_start(3, 0, 0);
    for (int k = 0; k <= 3; k++) begin
      chk("oneshot_count", count, k);
      chk("oneshot_tc_low", tc_pulse, 0);
      cyc();
    end
    chk("oneshot_tc", tc_pulse, 1);
    chk("oneshot_done", state, 3);
    chk("oneshot_hold", count, 3);
    chk("oneshot_irq", irq, 1);
    pause = 1;
    cyc();
    pause = 0;
    chk("oneshot_tc_once", tc_pulse, 0);
    chk("done_ignores_pause", state, 3);
    chk("done_count", count, 3);

    // async reset mid-run at count 5
    do_start(20, 0, 0);
    repeat (5) cyc();
    chk("pre_reset_count", count, 5);
    #2 reset_n = 0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_irq", irq, 0);
    @(negedge clk);
    reset_n = 1;
    cyc();

    // periodic, term 2, divide by 3
    do_start(2, 2, 1);
    for (int k = 0; k <= 18; k++) begin
      chk("per_count", count, (k / 3) % 3);
      chk("per_tc", tc_pulse, (k > 0 && k % 9 == 0) ? 1 : 0);
      chk("per_busy", busy, 1);
      cyc();
    end

    // pause preserves prescaler phase
    do_start(50, 1, 0);
    repeat (9) cyc();
    chk("pause_pre", count, 4);
    pause = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("pause_state", state, 2);
      chk("pause_count", count, 4);
    end
    pause = 0;
    cyc();
    chk("resume_state", state, 1);
    chk("resume_count", count, 4);
    cyc();
    chk("resume_phase", count, 5);

    // stop beats start
    start = 1; stop = 1;
    cyc();
    start = 0; stop = 0;
    chk("prio_state", state, 0);
    chk("prio_count", count, 0);
    chk("prio_tc", tc_pulse, 0);

    // restart at count 7 latches new term
    do_start(10, 0, 0);
    repeat (7) cyc();
    chk("restart_pre", count, 7);
    do_start(1, 0, 0);
    chk("restart_count", count, 0);
    chk("restart_state", state, 1);
    cyc();
    chk("restart_step", count, 1);
    cyc();
    chk("restart_term_tc", tc_pulse, 1);
    chk("restart_term_state", state, 3);
    chk("restart_term_count", count, 1);

    // irq handling, term 0 periodic no prescale
    irq_clr = 1;
    cyc();
    irq_clr = 0;
    chk("irq_clear", irq, 0);
    do_start(0, 0, 1);
    chk("t0_first", tc_pulse, 0);
    irq_clr = 1;
    cyc();
    irq_clr = 0;
    chk("t0_tc", tc_pulse, 1);
    chk("set_wins_irq", irq, 1);
    chk("t0_count", count, 0);
    cyc();
    chk("t0_tc_again", tc_pulse, 1);
    stop = 1; irq_clr = 1;
    cyc();
    stop = 0; irq_clr = 0;
    chk("stop_no_tc", tc_pulse, 0);
    chk("stop_irq_clr", irq, 0);
    chk("stop_idle", state, 0);

    // wrap 0xFF -> 0x00 via terminal step
    do_start(255, 0, 1);
    repeat (255) cyc();
    chk("wrap_ff", count, 255);
    cyc();
    chk("wrap_00", count, 0);
    chk("wrap_tc", tc_pulse, 1);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      stop     = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      periodic = $urandom_range(0, 1);
      load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      prescale = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      irq_clr  = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    start = 0; stop = 0; pause = 0; irq_clr = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
